// File: rtl/noc_input_port.sv
// Router input stage: flit FIFO plus XY route computation, locking the route for a wormhole packet.
// Orphan body/tail flits at the front while idle are dropped and flagged on the sticky err output.
module noc_input_port #(
    parameter int unsigned FLIT_W  = 64,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned MY_X    = 0,
    parameter int unsigned MY_Y    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLIT_W-1:0]          in_flit,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [FLIT_W-1:0]          out_flit,
    output logic                       out_valid,
    output logic [4:0]                 out_port,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [COORD_W-1:0] MyX = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MyY = COORD_W'(MY_Y);

    localparam logic [1:0] TypeBody   = 2'b00;
    localparam logic [1:0] TypeHead   = 2'b01;
    localparam logic [1:0] TypeTail   = 2'b10;
    localparam logic [1:0] TypeSingle = 2'b11;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    logic [FLIT_W-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    state_e             state_q, state_d;
    logic [4:0]         locked_q, locked_d;
    logic               err_q, err_d;

    logic               full, empty, push, pop, drop, deq;
    logic [FLIT_W-1:0]  front;
    logic [1:0]         ftype;
    logic [4:0]         front_route;

    function automatic logic [4:0] xy_route(input logic [COORD_W-1:0] dx,
                                            input logic [COORD_W-1:0] dy);
        logic [4:0] r;
        if (dx > MyX)      r = 5'b00010;
        else if (dx < MyX) r = 5'b01000;
        else if (dy > MyY) r = 5'b00100;
        else if (dy < MyY) r = 5'b00001;
        else               r = 5'b10000;
        return r;
    endfunction

    assign full        = (count_q == CntW'(DEPTH));
    assign empty       = (count_q == '0);
    assign front       = mem_q[rd_ptr_q];
    assign ftype       = front[FLIT_W-1 -: 2];
    assign front_route = xy_route(front[FLIT_W-3 -: COORD_W],
                                  front[FLIT_W-3-COORD_W -: COORD_W]);

    assign in_ready  = !rst && !full;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign deq       = pop || drop;
    assign out_flit  = front;
    assign occupancy = rst ? '0 : count_q;
    assign err       = err_q;

    always_comb begin
        out_valid = 1'b0;
        out_port  = 5'b0;
        drop      = 1'b0;
        state_d   = state_q;
        locked_d  = locked_q;
        err_d     = err_q;
        if (!rst && !empty) begin
            unique case (state_q)
                StIdle: begin
                    if (ftype == TypeHead || ftype == TypeSingle) begin
                        out_valid = 1'b1;
                        out_port  = front_route;
                        if (out_ready && ftype == TypeHead) begin
                            locked_d = front_route;
                            state_d  = StLocked;
                        end
                    end else begin
                        // Orphan body/tail: discard without presenting it.
                        drop  = 1'b1;
                        err_d = 1'b1;
                    end
                end
                StLocked: begin
                    out_valid = 1'b1;
                    out_port  = locked_q;
                    if (out_ready) begin
                        if (ftype == TypeHead || ftype == TypeSingle) err_d = 1'b1;
                        if (ftype == TypeTail || ftype == TypeSingle) state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            locked_q <= 5'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_flit;
    end

    // TypeBody is named for readability of the decode only.
    logic unused_body;
    assign unused_body = ^TypeBody;

endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port at MY=(1,1): per-cycle vector table plus a FIFO-full sequence.
module tb_noc_input_port;

    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] SNGL = 2'b11;

    localparam logic [4:0] PN = 5'b00001;
    localparam logic [4:0] PE = 5'b00010;
    localparam logic [4:0] PW = 5'b01000;
    localparam logic [4:0] PL = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_flit = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_flit;
    logic        out_valid;
    logic [4:0]  out_port;
    logic        out_ready = 1'b0;
    logic [2:0]  occupancy;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    noc_input_port #(
        .FLIT_W (64),
        .DEPTH  (4),
        .COORD_W(4),
        .MY_X   (1),
        .MY_Y   (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_flit  (in_flit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_flit (out_flit),
        .out_valid(out_valid),
        .out_port (out_port),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .err      (err)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [63:0] flit;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [4:0]  port;
        logic [2:0]  occ;
        logic        err;
        logic        chk_flit;
        logic [63:0] exp_flit;
    } vec_t;

    vec_t vq[$];

    function automatic logic [63:0] mk(input logic [1:0] t, input logic [3:0] x,
                                       input logic [3:0] y, input int p);
        return {t, x, y, 54'(p)};
    endfunction

    task automatic add(input logic r, input logic iv, input logic [63:0] f, input logic ordy,
                       input logic ir, input logic ov, input logic [4:0] port,
                       input logic [2:0] occ, input logic e, input logic cf,
                       input logic [63:0] ef);
        vec_t v;
        v.rst = r; v.iv = iv; v.flit = f; v.ordy = ordy;
        v.ir = ir; v.ov = ov; v.port = port; v.occ = occ; v.err = e;
        v.chk_flit = cf; v.exp_flit = ef;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [63:0] f [6];

        // Single to E, pop, then 4-flit packet to N.
        add(1, 0, 0, 0,                 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, mk(SNGL,2,1,1), 0,    1, 0, 0,  0, 0, 0, 0);
        add(0, 0, 0, 0,                 1, 1, PE, 1, 0, 1, mk(SNGL,2,1,1));
        add(0, 0, 0, 1,                 1, 1, PE, 1, 0, 1, mk(SNGL,2,1,1));
        add(0, 0, 0, 0,                 1, 0, 0,  0, 0, 0, 0);
        add(0, 1, mk(HEAD,1,0,2), 1,    1, 0, 0,  0, 0, 0, 0);
        add(0, 1, mk(BODY,0,0,3), 1,    1, 1, PN, 1, 0, 1, mk(HEAD,1,0,2));
        add(0, 1, mk(BODY,0,0,4), 1,    1, 1, PN, 1, 0, 1, mk(BODY,0,0,3));
        add(0, 1, mk(TAIL,0,0,5), 1,    1, 1, PN, 1, 0, 1, mk(BODY,0,0,4));
        add(0, 0, 0, 1,                 1, 1, PN, 1, 0, 1, mk(TAIL,0,0,5));
        add(0, 0, 0, 0,                 1, 0, 0,  0, 0, 0, 0);
        // Orphan body after reset: dropped, err sticky.
        add(1, 0, 0, 0,                 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, mk(BODY,2,2,6), 0,    1, 0, 0,  0, 0, 0, 0);
        add(0, 0, 0, 0,                 1, 0, 0,  1, 0, 0, 0);
        add(0, 0, 0, 1,                 1, 0, 0,  0, 1, 0, 0);
        add(0, 0, 0, 0,                 1, 0, 0,  0, 1, 0, 0);
        // Local route, reset mid-packet, then W route.
        add(1, 0, 0, 0,                 0, 0, 0,  0, 1, 0, 0);
        add(0, 1, mk(HEAD,1,1,7), 0,    1, 0, 0,  0, 0, 0, 0);
        add(0, 1, mk(BODY,0,0,8), 0,    1, 1, PL, 1, 0, 1, mk(HEAD,1,1,7));
        add(0, 1, mk(BODY,0,0,9), 1,    1, 1, PL, 2, 0, 1, mk(HEAD,1,1,7));
        add(0, 0, 0, 0,                 1, 1, PL, 2, 0, 1, mk(BODY,0,0,8));
        add(1, 0, 0, 0,                 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, mk(HEAD,0,1,10), 0,   1, 0, 0,  0, 0, 0, 0);
        add(0, 0, 0, 1,                 1, 1, PW, 1, 0, 1, mk(HEAD,0,1,10));
        add(0, 1, mk(TAIL,0,0,11), 0,   1, 0, 0,  0, 0, 0, 0);
        add(0, 0, 0, 1,                 1, 1, PW, 1, 0, 1, mk(TAIL,0,0,11));
        add(0, 0, 0, 0,                 1, 0, 0,  0, 0, 0, 0);

        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; in_valid = vq[i].iv; in_flit = vq[i].flit;
            out_ready = vq[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vq[i].ir));
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vq[i].ov));
            check($sformatf("v%0d out_port", i), 64'(out_port), 64'(vq[i].port));
            check($sformatf("v%0d occupancy", i), 64'(occupancy), 64'(vq[i].occ));
            check($sformatf("v%0d err", i), 64'(err), 64'(vq[i].err));
            if (vq[i].chk_flit) check($sformatf("v%0d out_flit", i), out_flit, vq[i].exp_flit);
        end

        // Fill beyond DEPTH with out_ready low, then drain in order.
        f[0] = mk(HEAD,2,1,20); f[1] = mk(BODY,0,0,21); f[2] = mk(BODY,0,0,22);
        f[3] = mk(TAIL,0,0,23); f[4] = mk(BODY,0,0,24); f[5] = mk(TAIL,0,0,25);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst = 1'b0; in_valid = 1'b1; in_flit = f[i];
            #1;
            check($sformatf("fill%0d in_ready", i), 64'(in_ready), 64'(i < 4));
            if (i > 0) begin
                check($sformatf("fill%0d out_flit", i), out_flit, f[0]);
                check($sformatf("fill%0d out_port", i), 64'(out_port), 64'(PE));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full occupancy", 64'(occupancy), 64'd4);
        check("full in_ready", 64'(in_ready), 64'd0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            check($sformatf("drain%0d out_valid", j), 64'(out_valid), 64'd1);
            check($sformatf("drain%0d out_flit", j), out_flit, f[j]);
            check($sformatf("drain%0d out_port", j), 64'(out_port), 64'(PE));
            check($sformatf("drain%0d in_ready", j), 64'(in_ready), 64'(j > 0));
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("drained out_valid", 64'(out_valid), 64'd0);
        check("drained occupancy", 64'(occupancy), 64'd0);
        check("drained err", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
